// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   8N1 UART receiver. The serial input is synchronised, sampled 16 times per
//   bit, each bit is taken as the majority of samples 7/8/9, and the stop bit
//   is checked. Received bytes go into a one-entry holding register that is
//   read with a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   uart_rx_i    asynchronous serial input, idle high
//   rx_data_o    received byte, stable while rx_valid_o is high
//   rx_valid_o   holding register full
//   rx_ready_i   consumer takes the byte when rx_valid_o & rx_ready_i
//   frame_err_o  1-clk pulse, stop bit sampled low, byte dropped
//   overrun_o    1-clk pulse, byte arrived while register full and not read
//   busy_o       receiver not in IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, looking for a low sample on a tick
// START     | inside start bit, confirming it at mid-bit
// DATA      | sampling the 8 data bits, LSB first
// STOP      | sampling the stop bit, commit or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high

module uart_rx_oversample #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV = (CLK_HZ + BAUD * OVS / 2) / (BAUD * OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] tcnt;
  logic          tick;
  logic [3:0]    scnt;
  logic [2:0]    bidx;
  logic [2:0]    state;
  logic          smp7;
  logic          smp8;
  logic [7:0]    shreg;
  logic          vote;
  logic          at_vote;
  logic          commit;
  logic          ferr_set;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Free-running tick divider, one tick per 1/16 bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == DIV_M1);

  // Samples 7 and 8 are held; sample 9 is the live rx_s on the vote tick.
  always_comb begin
    vote     = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
    at_vote  = tick && (scnt == 4'd9);
    commit   = at_vote && (state == ST_STOP) && vote;
    ferr_set = at_vote && (state == ST_STOP) && !vote;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      scnt  <= 4'd0;
      bidx  <= 3'd0;
      smp7  <= 1'b1;
      smp8  <= 1'b1;
      shreg <= 8'h00;
    end else begin
      if (tick) begin
        scnt <= scnt + 4'd1;
        if (scnt == 4'd7) smp7 <= rx_s;
        if (scnt == 4'd8) smp8 <= rx_s;
      end
      case (state)
        ST_IDLE: begin
          // Realign the sample counter to the detected falling edge.
          if (tick && !rx_s) begin
            scnt  <= 4'd0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state <= ST_IDLE;
          end else if (tick && scnt == 4'd15) begin
            state <= ST_DATA;
            bidx  <= 3'd0;
          end
        end
        ST_DATA: begin
          if (at_vote) shreg <= {vote, shreg[7:1]};
          if (tick && scnt == 4'd15) begin
            if (bidx == 3'd7) state <= ST_STOP;
            else              bidx  <= bidx + 3'd1;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (at_vote) state <= vote ? ST_IDLE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_set;
      overrun_o   <= commit && rx_valid_o && !rx_ready_i;
      if (commit && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= shreg;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  // 50 MHz clock, 390625 baud -> exactly 8 clks per tick, 2560 ns per bit.
  localparam real BIT_NS  = 2560.0;
  localparam real FAST_NS = 2560.0 / 1.03;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int n_vcyc   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_oversample #(.CLK_HZ(50_000_000), .BAUD(390_625)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx_i  (uart_rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard monitor: every handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, rx_data}, 32'h100);
        end else begin
          exp_b = exp_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
        end
      end
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rx_valid)  n_vcyc++;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns);
    uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(bit_ns);
    end
    uart_rx = stop;
    #(bit_ns);
  endtask

  int d0, f0, o0, v0;
  task automatic snap();
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    chk("rst_data",  {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * BIT_NS);

    // 1: single byte, consumer always ready
    snap();
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, BIT_NS);
    repeat (20) @(posedge clk);
    chk("t1_deliv",  n_deliv - d0, 1);
    chk("t1_vcyc",   n_vcyc - v0, 1);
    chk("t1_errs",   (n_ferr - f0) + (n_ovr - o0), 0);
    chk("t1_hold",   {24'd0, rx_data}, 32'h41);
    #(2 * BIT_NS);

    // 2: overrun while not ready
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, BIT_NS);
    #(BIT_NS);
    send_frame(8'h44, 1'b1, BIT_NS);
    repeat (20) @(posedge clk);
    chk("t2_ovr",    n_ovr - o0, 1);
    chk("t2_data",   {24'd0, rx_data}, 32'h42);
    chk("t2_valid",  {31'd0, rx_valid}, 32'd1);
    chk("t2_nodel",  n_deliv - d0, 0);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t2_drop",   {31'd0, rx_valid}, 32'd0);
    chk("t2_deliv",  n_deliv - d0, 1);
    #(2 * BIT_NS);

    // 3: glitch shorter than half a bit is a false start
    snap();
    uart_rx = 1'b0;
    #400;
    uart_rx = 1'b1;
    #60;
    chk("t3_busy_hi", {31'd0, busy}, 32'd1);
    #(BIT_NS - 460.0);
    chk("t3_busy_lo", {31'd0, busy}, 32'd0);
    #(BIT_NS);
    chk("t3_vcyc",   n_vcyc - v0, 0);
    chk("t3_ferr",   n_ferr - f0, 0);

    // 4: framing error followed by a break, then a good byte
    snap();
    send_frame(8'h55, 1'b0, BIT_NS);
    #(3 * BIT_NS);
    chk("t4_ferr1",  n_ferr - f0, 1);
    chk("t4_nobyte", n_vcyc - v0, 0);
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    chk("t4_idle",   {31'd0, busy}, 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_NS);
    repeat (20) @(posedge clk);
    chk("t4_deliv",  n_deliv - d0, 1);
    chk("t4_ferr",   n_ferr - f0, 1);
    #(2 * BIT_NS);

    // 5: back-to-back frames at nominal and +3% rate
    for (int r = 0; r < 2; r++) begin
      snap();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, (r == 0) ? BIT_NS : FAST_NS);
      send_frame(8'hFF, 1'b1, (r == 0) ? BIT_NS : FAST_NS);
      repeat (40) @(posedge clk);
      chk(r == 0 ? "t5_deliv_nom" : "t5_deliv_fast", n_deliv - d0, 2);
      chk(r == 0 ? "t5_ferr_nom" : "t5_ferr_fast", n_ferr - f0, 0);
      #(2 * BIT_NS);
    end

    // 6: reset during data bit 4
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      #(BIT_NS);
    end
    uart_rx = 1'b1;
    #(BIT_NS / 2.0);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy",  {31'd0, busy}, 32'd0);
    chk("t6_data",  {24'd0, rx_data}, 32'h0);
    chk("t6_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6_pulses", {30'd0, frame_err, overrun}, 32'd0);
    #(BIT_NS);
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS);
    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NS);
    repeat (20) @(posedge clk);
    chk("t6_deliv", n_deliv - d0, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
